pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl.sv | 93 +++++++++
 tb/tb_pipe_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-latch stall vector, exception/ERET flush sequencer,
// stall performance counter and consecutive-stall watchdog.
module pipe_ctrl #(
  parameter int N_STAGE   = 5,
  parameter int FLUSH_LEN = 1,
  parameter int TIMEOUT   = 1024,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_STAGE-1:0] stallreq,
  input  logic               exc_valid,
  input  logic [31:0]        exc_target,
  input  logic               clr_stat,
  output logic [N_STAGE:0]   stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               busy_flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               stall_timeout
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam int         TW    = $clog2(TIMEOUT + 1);

  logic [0:0]    state;
  logic [3:0]    flush_cnt;
  logic [TW-1:0] stall_run, stall_run_nxt;
  logic          in_run, any_stall;

  assign in_run = (state == RUN);

  // Latch j holds when any stage j or later stalls; the latch just past the
  // highest stalling stage is released so the next stage sees a bubble.
  for (genvar j = 0; j < N_STAGE; j++) begin : g_stall
    assign stall[j] = in_run & (|stallreq[N_STAGE-1:j]);
  end
  assign stall[N_STAGE] = 1'b0;

  assign any_stall  = |stall;
  assign flush      = (state == FLUSH);
  assign busy_flush = (state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      new_pc    <= '0;
    end else if (state == RUN) begin
      if (exc_valid) begin
        state     <= FLUSH;
        flush_cnt <= 4'(FLUSH_LEN);
        new_pc    <= exc_target;
      end
    end else begin
      if (flush_cnt <= 4'd1) begin
        state     <= RUN;
        flush_cnt <= '0;
      end else begin
        flush_cnt <= flush_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    stall_run_nxt = stall_run;
    if (!any_stall || !in_run)
      stall_run_nxt = '0;
    else if (stall_run != TW'(TIMEOUT))
      stall_run_nxt = stall_run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_run     <= '0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_run <= stall_run_nxt;
      if (clr_stat)
        stall_cnt <= '0;
      else if (any_stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
      // flag rises on the same edge the run counter reaches TIMEOUT
      if (clr_stat)
        stall_timeout <= 1'b0;
      else if (any_stall && stall_run_nxt == TW'(TIMEOUT))
        stall_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall encoding table plus flush, counter,
// watchdog and reset-mid-flush sequences across three parameterisations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stallreq;
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        clr_stat;

  logic [5:0]  s0, s1, s2;
  logic        f0, f1, f2, b0, b1, b2, t0, t1, t2;
  logic [31:0] pc0, pc1, pc2, c0, c2;
  logic [3:0]  c1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl u0 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .exc_valid(exc_valid),
    .exc_target(exc_target), .clr_stat(clr_stat), .stall(s0), .flush(f0),
    .new_pc(pc0), .busy_flush(b0), .stall_cnt(c0), .stall_timeout(t0));

  pipe_ctrl #(.FLUSH_LEN(3), .TIMEOUT(8), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .exc_valid(exc_valid),
    .exc_target(exc_target), .clr_stat(clr_stat), .stall(s1), .flush(f1),
    .new_pc(pc1), .busy_flush(b1), .stall_cnt(c1), .stall_timeout(t1));

  pipe_ctrl #(.FLUSH_LEN(4)) u2 (
    .clk(clk), .rst(rst), .stallreq(stallreq), .exc_valid(exc_valid),
    .exc_target(exc_target), .clr_stat(clr_stat), .stall(s2), .flush(f2),
    .new_pc(pc2), .busy_flush(b2), .stall_cnt(c2), .stall_timeout(t2));

  typedef struct {
    logic [4:0] req;
    logic [5:0] exp;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stallreq = '0; exc_valid = 1'b0; exc_target = '0; clr_stat = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    vt[0] = '{5'b00000, 6'b000000};
    vt[1] = '{5'b00001, 6'b000001};
    vt[2] = '{5'b00010, 6'b000011};
    vt[3] = '{5'b00100, 6'b000111};
    vt[4] = '{5'b01010, 6'b001111};
    vt[5] = '{5'b10000, 6'b011111};
    vt[6] = '{5'b11111, 6'b011111};
    vt[7] = '{5'b00011, 6'b000011};

    do_reset();
    #1;
    chk("rst_stall", s0, 0);
    chk("rst_flush", f0, 0);
    chk("rst_new_pc", pc0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_cnt", c0, 0);
    chk("rst_timeout", t0, 0);

    // stall encoding table
    for (int i = 0; i < 8; i++) begin
      stallreq = vt[i].req;
      #1;
      chk($sformatf("stall_vec%0d", i), s0, vt[i].exp);
    end
    stallreq = '0;

    // single flush, FLUSH_LEN=1
    do_reset();
    exc_valid = 1'b1; exc_target = 32'hBFC00380;
    step();
    exc_valid = 1'b0; stallreq = 5'b00100;
    #1;
    chk("sf_flush", f0, 1);
    chk("sf_busy", b0, 1);
    chk("sf_new_pc", pc0, 32'hBFC00380);
    chk("sf_stall_suppr", s0, 0);
    step();
    chk("sf_flush_end", f0, 0);
    chk("sf_busy_end", b0, 0);
    chk("sf_stall_run", s0, 6'b000111);
    stallreq = '0;

    // long flush with stall clash, FLUSH_LEN=3
    do_reset();
    exc_valid = 1'b1; exc_target = 32'h12345678; stallreq = 5'b00001;
    #1;
    chk("lf_stall_same_cyc", s1, 6'b000001);
    step();
    exc_valid = 1'b0; stallreq = '0;
    chk("lf_flush_c1", f1, 1);
    step();
    exc_valid = 1'b1; exc_target = 32'h0;
    #1;
    chk("lf_flush_c2", f1, 1);
    step();
    exc_valid = 1'b0;
    chk("lf_flush_c3", f1, 1);
    chk("lf_new_pc_hold", pc1, 32'h12345678);
    step();
    chk("lf_flush_done", f1, 0);
    chk("lf_busy_done", b1, 0);
    chk("lf_new_pc_final", pc1, 32'h12345678);
    step();
    chk("lf_second_ignored", f1, 0);

    // performance counter and clear
    do_reset();
    stallreq = 5'b00100;
    repeat (7) step();
    stallreq = '0;
    chk("cnt_7", c0, 7);
    clr_stat = 1'b1; stallreq = 5'b00001;
    step();
    clr_stat = 1'b0; stallreq = '0;
    chk("cnt_clr_wins", c0, 0);
    step();
    chk("cnt_idle", c0, 0);

    // saturation on 4-bit counter
    do_reset();
    stallreq = 5'b00010;
    repeat (20) step();
    stallreq = '0;
    chk("cnt_sat", c1, 15);
    chk("cnt_wide", c0, 20);
    chk("wd_not_tripped_1024", t0, 0);

    // watchdog, TIMEOUT=8
    do_reset();
    stallreq = 5'b00001;
    repeat (7) step();
    chk("wd_7", t1, 0);
    step();
    chk("wd_8", t1, 1);
    stallreq = '0;
    step();
    chk("wd_sticky", t1, 1);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    chk("wd_clr", t1, 0);
    stallreq = 5'b00001;
    repeat (7) step();
    stallreq = '0;
    step();
    stallreq = 5'b00001;
    repeat (7) step();
    stallreq = '0;
    chk("wd_gap", t1, 0);

    // reset in the middle of a FLUSH_LEN=4 flush
    do_reset();
    stallreq = 5'b00001;
    repeat (3) step();
    stallreq = '0;
    chk("rmf_cnt_pre", c2, 3);
    exc_valid = 1'b1; exc_target = 32'hAAAA0000;
    step();
    exc_valid = 1'b0;
    chk("rmf_flush_c1", f2, 1);
    step();
    chk("rmf_flush_c2", f2, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmf_flush", f2, 0);
    chk("rmf_busy", b2, 0);
    chk("rmf_new_pc", pc2, 0);
    chk("rmf_cnt", c2, 0);
    stallreq = 5'b00001;
    #1;
    chk("rmf_run_stall", s2, 6'b000001);
    stallreq = '0;
    step();
    chk("rmf_stays_run", f2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
